// File: rtl/rf_scoreboard.sv
// Two-read / two-write register file with 1-cycle registered reads, write bypass,
// and a per-register busy scoreboard that tracks outstanding producers.
module rf_scoreboard #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rd_addr1,
    input  logic [AW-1:0] rd_addr2,
    input  logic          rd_req1,
    input  logic          rd_req2,
    output logic [DW-1:0] rd_data1,
    output logic [DW-1:0] rd_data2,
    input  logic          wr_en0,
    input  logic [AW-1:0] wr_addr0,
    input  logic [DW-1:0] wr_data0,
    input  logic          wr_en1,
    input  logic [AW-1:0] wr_addr1,
    input  logic [DW-1:0] wr_data1,
    input  logic          iss_en,
    input  logic [AW-1:0] iss_addr,
    output logic          busy1,
    output logic          busy2,
    output logic          stall,
    output logic [AW:0]   busy_cnt
);

    localparam int DEPTH    = 1 << AW;
    localparam bit HAS_ZERO = (ZERO_REG != 0);

    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] busy_bits;

    logic             w0_ok, w1_ok, iss_ok;
    logic             hit0_1, hit1_1, hit0_2, hit1_2;
    logic [DW-1:0]    rd_next1, rd_next2;
    logic [DEPTH-1:0] clr_mask, set_mask, busy_next;
    logic             inc, dec0, dec1;
    logic [AW:0]      cnt_next;

    // Writes and issues aimed at the hardwired zero register are dropped up front.
    always_comb begin
        w0_ok  = wr_en0 && !(HAS_ZERO && wr_addr0 == '0);
        w1_ok  = wr_en1 && !(HAS_ZERO && wr_addr1 == '0);
        iss_ok = iss_en && !(HAS_ZERO && iss_addr == '0);

        hit0_1 = w0_ok && (wr_addr0 == rd_addr1);
        hit1_1 = w1_ok && (wr_addr1 == rd_addr1);
        hit0_2 = w0_ok && (wr_addr0 == rd_addr2);
        hit1_2 = w1_ok && (wr_addr1 == rd_addr2);
    end

    always_comb begin
        rd_next1 = mem[rd_addr1];
        if (hit0_1) rd_next1 = wr_data0;
        if (hit1_1) rd_next1 = wr_data1;
        if (HAS_ZERO && rd_addr1 == '0) rd_next1 = '0;

        rd_next2 = mem[rd_addr2];
        if (hit0_2) rd_next2 = wr_data0;
        if (hit1_2) rd_next2 = wr_data1;
        if (HAS_ZERO && rd_addr2 == '0) rd_next2 = '0;
    end

    // A writeback landing this cycle satisfies the operand, so it must not stall.
    always_comb begin
        busy1 = busy_bits[rd_addr1] && !(hit0_1 || hit1_1);
        busy2 = busy_bits[rd_addr2] && !(hit0_2 || hit1_2);
        stall = (busy1 && rd_req1) || (busy2 && rd_req2);
    end

    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (w0_ok)  clr_mask[wr_addr0] = 1'b1;
        if (w1_ok)  clr_mask[wr_addr1] = 1'b1;
        if (iss_ok) set_mask[iss_addr] = 1'b1;
        busy_next = (busy_bits & ~clr_mask) | set_mask;

        // Incremental count: an issue to the written address keeps the bit set,
        // and two ports clearing the same bit only count once.
        inc  = iss_ok && !busy_bits[iss_addr];
        dec0 = w0_ok && busy_bits[wr_addr0] && !(iss_ok && iss_addr == wr_addr0);
        dec1 = w1_ok && busy_bits[wr_addr1] && !(iss_ok && iss_addr == wr_addr1)
               && !(w0_ok && wr_addr0 == wr_addr1);
        cnt_next = busy_cnt + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec0} - {{AW{1'b0}}, dec1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            busy_bits <= '0;
            rd_data1  <= '0;
            rd_data2  <= '0;
            busy_cnt  <= '0;
        end else begin
            if (w0_ok) mem[wr_addr0] <= wr_data0;
            if (w1_ok) mem[wr_addr1] <= wr_data1;
            rd_data1  <= rd_next1;
            rd_data2  <= rd_next2;
            busy_bits <= busy_next;
            busy_cnt  <= cnt_next;
        end
    end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Table-driven bench for rf_scoreboard; registered outputs are checked through a
// queue of expected values pushed when each vector is driven.
module tb_rf_scoreboard;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rd_addr1, rd_addr2;
    logic          rd_req1, rd_req2;
    logic [DW-1:0] rd_data1, rd_data2;
    logic          wr_en0, wr_en1;
    logic [AW-1:0] wr_addr0, wr_addr1;
    logic [DW-1:0] wr_data0, wr_data1;
    logic          iss_en;
    logic [AW-1:0] iss_addr;
    logic          busy1, busy2, stall;
    logic [AW:0]   busy_cnt;

    typedef struct {
        logic          rst;
        logic [AW-1:0] a1, a2;
        logic          q1, q2;
        logic          we0;
        logic [AW-1:0] wa0;
        logic [DW-1:0] wd0;
        logic          we1;
        logic [AW-1:0] wa1;
        logic [DW-1:0] wd1;
        logic          ie;
        logic [AW-1:0] ia;
        logic          eb1, eb2, es;
        logic [DW-1:0] er1, er2;
        logic [AW:0]   ec;
    } vec_t;

    typedef struct {
        logic [DW-1:0] rd1, rd2;
        logic [AW:0]   cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t expq[$];
    int   checks = 0;
    int   passed = 0;

    rf_scoreboard #(.DW(DW), .AW(AW), .ZERO_REG(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_req1  (rd_req1),
        .rd_req2  (rd_req2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2),
        .wr_en0   (wr_en0),
        .wr_addr0 (wr_addr0),
        .wr_data0 (wr_data0),
        .wr_en1   (wr_en1),
        .wr_addr1 (wr_addr1),
        .wr_data1 (wr_data1),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .busy1    (busy1),
        .busy2    (busy2),
        .stall    (stall),
        .busy_cnt (busy_cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input int r, input int a1, input int a2, input int q1, input int q2,
                                input int we0, input int wa0, input logic [31:0] wd0,
                                input int we1, input int wa1, input logic [31:0] wd1,
                                input int ie, input int ia,
                                input int eb1, input int eb2, input int es,
                                input logic [31:0] er1, input logic [31:0] er2, input int ec);
        vec_t v;
        v.rst = 1'(r);   v.a1 = 5'(a1);  v.a2 = 5'(a2);  v.q1 = 1'(q1);  v.q2 = 1'(q2);
        v.we0 = 1'(we0); v.wa0 = 5'(wa0); v.wd0 = wd0;
        v.we1 = 1'(we1); v.wa1 = 5'(wa1); v.wd1 = wd1;
        v.ie  = 1'(ie);  v.ia  = 5'(ia);
        v.eb1 = 1'(eb1); v.eb2 = 1'(eb2); v.es = 1'(es);
        v.er1 = er1;     v.er2 = er2;     v.ec = 6'(ec);
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        exp_t e;
        @(negedge clk);
        rst      = v.rst;
        rd_addr1 = v.a1;  rd_addr2 = v.a2;  rd_req1 = v.q1;  rd_req2 = v.q2;
        wr_en0   = v.we0; wr_addr0 = v.wa0; wr_data0 = v.wd0;
        wr_en1   = v.we1; wr_addr1 = v.wa1; wr_data1 = v.wd1;
        iss_en   = v.ie;  iss_addr = v.ia;
        expq.push_back('{v.er1, v.er2, v.ec});
        #1;
        checkOutput({tag, " busy1"}, {31'b0, busy1}, {31'b0, v.eb1});
        checkOutput({tag, " busy2"}, {31'b0, busy2}, {31'b0, v.eb2});
        checkOutput({tag, " stall"}, {31'b0, stall}, {31'b0, v.es});
        @(posedge clk);
        #1;
        e = expq.pop_front();
        checkOutput({tag, " rd_data1"}, rd_data1, e.rd1);
        checkOutput({tag, " rd_data2"}, rd_data2, e.rd2);
        checkOutput({tag, " busy_cnt"}, {26'b0, busy_cnt}, {26'b0, e.cnt});
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // mk(rst, a1,a2,q1,q2, we0,wa0,wd0, we1,wa1,wd1, ie,ia, eb1,eb2,stall, rd1,rd2,cnt)
        vecs.push_back(mk(1, 0,0,0,0, 0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0));
        vecs.push_back(mk(0, 5,0,0,0, 1,5,32'hDEADBEEF, 0,0,0, 0,0, 0,0,0, 32'hDEADBEEF,0,0));
        vecs.push_back(mk(0, 5,5,0,0, 0,0,0, 0,0,0, 0,0, 0,0,0, 32'hDEADBEEF,32'hDEADBEEF,0));
        vecs.push_back(mk(0, 5,7,0,0, 1,7,'h11, 1,7,'h22, 0,0, 0,0,0, 32'hDEADBEEF,'h22,0));
        vecs.push_back(mk(0, 7,7,0,0, 0,0,0, 0,0,0, 0,0, 0,0,0, 'h22,'h22,0));
        vecs.push_back(mk(0, 0,7,0,0, 1,0,'h1234, 0,0,0, 1,0, 0,0,0, 0,'h22,0));
        vecs.push_back(mk(0, 0,0,0,0, 0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0));
        vecs.push_back(mk(0, 3,0,1,0, 0,0,0, 0,0,0, 1,3, 0,0,0, 0,0,1));
        vecs.push_back(mk(0, 3,0,1,0, 0,0,0, 0,0,0, 0,0, 1,0,1, 0,0,1));
        vecs.push_back(mk(0, 3,0,1,0, 1,3,'h33, 0,0,0, 0,0, 0,0,0, 'h33,0,0));
        vecs.push_back(mk(0, 0,3,0,1, 0,0,0, 0,0,0, 0,0, 0,0,0, 0,'h33,0));
        vecs.push_back(mk(0, 0,0,0,0, 0,0,0, 0,0,0, 1,9, 0,0,0, 0,0,1));
        vecs.push_back(mk(0, 9,0,1,0, 0,0,0, 1,9,'h99, 1,9, 0,0,0, 'h99,0,1));
        vecs.push_back(mk(0, 9,9,1,0, 0,0,0, 0,0,0, 0,0, 1,1,1, 'h99,'h99,1));
        vecs.push_back(mk(0, 9,9,0,0, 0,0,0, 0,0,0, 0,0, 1,1,0, 'h99,'h99,1));
        vecs.push_back(mk(0, 10,0,0,0, 1,10,'hA0, 1,10,'hA1, 1,10, 0,0,0, 'hA1,0,2));
        vecs.push_back(mk(0, 10,9,1,1, 0,0,0, 0,0,0, 0,0, 1,1,1, 'hA1,'h99,2));
        vecs.push_back(mk(0, 9,10,1,1, 1,9,'h5, 1,10,'h6, 0,0, 0,0,0, 'h5,'h6,0));
        vecs.push_back(mk(0, 0,0,0,0, 0,0,0, 0,0,0, 1,12, 0,0,0, 0,0,1));
        vecs.push_back(mk(0, 12,0,1,0, 1,12,'h1, 1,12,'h2, 0,0, 0,0,0, 'h2,0,0));
        vecs.push_back(mk(0, 13,0,0,0, 1,13,'h13, 0,0,0, 1,14, 0,0,0, 'h13,0,1));
        vecs.push_back(mk(0, 0,0,0,0, 0,0,0, 0,0,0, 1,4, 0,0,0, 0,0,2));
        vecs.push_back(mk(0, 0,0,0,0, 0,0,0, 0,0,0, 1,6, 0,0,0, 0,0,3));
        vecs.push_back(mk(0, 4,0,0,0, 0,0,0, 0,0,0, 1,8, 1,0,0, 0,0,4));
        vecs.push_back(mk(1, 5,4,0,1, 1,5,'hFF, 0,0,0, 1,15, 0,1,1, 0,0,0));
        vecs.push_back(mk(0, 4,5,1,1, 0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0));
        vecs.push_back(mk(0, 15,0,1,0, 0,0,0, 0,0,0, 1,20, 0,0,0, 0,0,1));
        vecs.push_back(mk(1, 0,0,0,0, 0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0));

        rst = 1'b1;
        rd_addr1 = '0; rd_addr2 = '0; rd_req1 = 1'b0; rd_req2 = 1'b0;
        wr_en0 = 1'b0; wr_addr0 = '0; wr_data0 = '0;
        wr_en1 = 1'b0; wr_addr1 = '0; wr_data1 = '0;
        iss_en = 1'b0; iss_addr = '0;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) applyStimulus(vecs[i], $sformatf("v%0d", i));

        // Fill every non-zero register, then confirm the count saturates at 31.
        for (int i = 1; i < 32; i++)
            applyStimulus(mk(0, 0,0,0,0, 0,0,0, 0,0,0, 1,i, 0,0,0, 0,0,i), $sformatf("fill%0d", i));
        applyStimulus(mk(0, 31,30,1,0, 0,0,0, 0,0,0, 1,1, 1,1,1, 0,0,31), "reissue_r1");
        applyStimulus(mk(0, 0,0,0,0, 0,0,0, 0,0,0, 1,0, 0,0,0, 0,0,31), "issue_r0_full");

        // Drain two registers per cycle from opposite ends.
        for (int i = 1; i < 16; i++)
            applyStimulus(mk(0, i,32-i,1,1, 1,i,32'(i), 1,32-i,32'(100+i), 0,0, 0,0,0,
                             32'(i),32'(100+i),31-2*i), $sformatf("drain%0d", i));
        applyStimulus(mk(0, 16,0,1,0, 1,16,'h16, 0,0,0, 0,0, 0,0,0, 'h16,0,0), "drain16");
        applyStimulus(mk(0, 1,31,1,1, 0,0,0, 0,0,0, 0,0, 0,0,0, 1,101,0), "drain_readback");

        if (expq.size() != 0) begin
            checks++;
            $display("[TB] FAIL expq_leftover: got %0d, expected 0", expq.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
